mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory, one access per grant.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Handshake: a requester raises req with stable operands and holds both until its
    // done pulse; req is sampled only in IDLE, so req still high after done is a new request.

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nx;
    logic              win_d;
    logic              grant_d;
    logic              any_req;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;

    assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // A tie goes to whichever port was not served by the previous grant.
    always_comb grant_d = d_req & (~if_req | ~last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_d <= grant_d;
        end
    end
`else
    always_comb grant_d = d_req;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ACCESS;
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            win_d     <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                win_d     <= grant_d;
                lat_addr  <= grant_d ? d_addr : if_addr;
                lat_we    <= grant_d & d_we;
                lat_wdata <= grant_d ? d_wdata : '0;
            end
            if (state == ACCESS) begin
                if (win_d) d_rdata  <= lat_we ? '0 : mem_rdata;
                else       if_rdata <= mem_rdata;
            end
        end
    end

    // Memory strobes decode the current state only, so a write in flight during reset commits.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (state == ACCESS) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_rd    = ~lat_we;
            mem_wr    = lat_we;
        end
    end

    assign if_done = (state == DONE) & ~win_d;
    assign d_done  = (state == DONE) &  win_d;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences and a
// randomized phase checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [7:0]  if_addr, d_addr, mem_addr;
    logic [15:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        if_done, d_done, mem_rd, mem_wr, busy;

    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level model state
    logic [15:0] ref_mem [0:255];
    bit          m_last_data;
    logic [15:0] m_if_rdata, m_d_rdata;

    typedef struct {
        bit          uf, ud, we;
        logic [7:0]  fa, da;
        logic [15:0] wd;
        bit          dfirst;
        logic [15:0] e_if, e_d;
    } vec_t;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
    end

    // Predict the result of a round: service order and final rdata values.
    task automatic predict(input bit uf, ud, we, input logic [7:0] fa, da,
                           input logic [15:0] wd,
                           output bit dfirst, output logic [15:0] e_if, e_d);
`ifdef MEM_ARB_RR_EN
        dfirst = (uf && ud) ? !m_last_data : ud;
`else
        dfirst = ud;
`endif
        if (uf && !dfirst) m_if_rdata = ref_mem[fa];
        if (ud) begin
            if (we) begin
                ref_mem[da] = wd;
                m_d_rdata = 16'h0;
            end else begin
                m_d_rdata = ref_mem[da];
            end
        end
        if (uf && dfirst) m_if_rdata = ref_mem[fa];
        m_last_data = (uf && ud) ? !dfirst : ud;
        e_if = m_if_rdata;
        e_d  = m_d_rdata;
    endtask

    task automatic run_pair(input bit uf, ud, we, input logic [7:0] fa, da,
                            input logic [15:0] wd, input bit dfirst,
                            input logic [15:0] e_if, e_d);
        int cyc = 0, d_at = -1, f_at = -1, strobes = 0;
        @(negedge clk);
        if_req = uf; if_addr = fa;
        d_req = ud; d_we = we; d_addr = da; d_wdata = wd;
        while (((uf && f_at < 0) || (ud && d_at < 0)) && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (mem_rd || mem_wr) strobes++;
            if (d_done) begin d_at = cyc; d_req = 1'b0; end
            if (if_done) begin f_at = cyc; if_req = 1'b0; end
        end
        if_req = 1'b0; d_req = 1'b0;
        if (uf && ud) begin
            check("first_done", dfirst ? d_at : f_at, 2);
            check("second_done", dfirst ? f_at : d_at, 5);
        end else if (ud) begin
            check("d_done_lat", d_at, 2);
        end else begin
            check("if_done_lat", f_at, 2);
        end
        check("strobe_cycles", strobes, uf + ud);
        check("if_rdata", if_rdata, e_if);
        check("d_rdata", d_rdata, e_d);
    endtask

    initial begin
        vec_t        vecs [5];
        bit          dfx;
        logic [15:0] eif, ed;
        string       seq, exp_seq;
        int          cyc, n_done;
        int          done_at [4];

        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        mem[8'h20] = 16'hA5A5; ref_mem[8'h20] = 16'hA5A5;
        mem[8'h30] = 16'h3030; ref_mem[8'h30] = 16'h3030;
        mem[8'h31] = 16'h3131; ref_mem[8'h31] = 16'h3131;
        m_last_data = 1'b0; m_if_rdata = 16'h0; m_d_rdata = 16'h0;

        vecs[0] = '{uf:0, ud:1, we:1, fa:8'h00, da:8'h10, wd:16'hBEEF, dfirst:1, e_if:16'h0000, e_d:16'h0000};
        vecs[1] = '{uf:1, ud:0, we:0, fa:8'h10, da:8'h00, wd:16'h0000, dfirst:0, e_if:16'hBEEF, e_d:16'h0000};
        vecs[2] = '{uf:1, ud:1, we:0, fa:8'h20, da:8'h20, wd:16'h0000, dfirst:1, e_if:16'hA5A5, e_d:16'hA5A5};
        vecs[3] = '{uf:0, ud:1, we:0, fa:8'h00, da:8'h10, wd:16'h0000, dfirst:1, e_if:16'hA5A5, e_d:16'hBEEF};
`ifdef MEM_ARB_RR_EN
        vecs[4] = '{uf:1, ud:1, we:1, fa:8'h40, da:8'h40, wd:16'h4444, dfirst:0, e_if:16'h0000, e_d:16'h0000};
`else
        vecs[4] = '{uf:1, ud:1, we:1, fa:8'h40, da:8'h40, wd:16'h4444, dfirst:1, e_if:16'h4444, e_d:16'h0000};
`endif

        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 8'h0; d_addr = 8'h0; d_wdata = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, if_done, d_done, mem_rd, mem_wr, mem_addr, mem_wdata},
              32'd0);
        check("reset_rdata", {if_rdata, d_rdata}, 32'd0);
        rst = 1'b0;

        // vector table
        for (int i = 0; i < 5; i++) begin
            predict(vecs[i].uf, vecs[i].ud, vecs[i].we, vecs[i].fa, vecs[i].da, vecs[i].wd,
                    dfx, eif, ed);
            run_pair(vecs[i].uf, vecs[i].ud, vecs[i].we, vecs[i].fa, vecs[i].da, vecs[i].wd,
                     vecs[i].dfirst, vecs[i].e_if, vecs[i].e_d);
        end
        check("mem_10_written", mem[8'h10], 16'hBEEF);

        // operand change after the grant is ignored
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
        @(negedge clk);
        d_addr = 8'h31;
        check("latched_addr", {mem_rd, mem_addr}, {23'd0, 1'b1, 8'h30});
        @(negedge clk);
        check("latched_done", d_done, 1'b1);
        check("latched_rdata", d_rdata, 16'h3030);
        d_req = 1'b0;
        m_d_rdata = 16'h3030; m_last_data = 1'b1;

        // reset during the ACCESS cycle of a write
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 16'h1234;
        @(negedge clk);
        check("rst_access_wr", mem_wr, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_commit", mem[8'h05], 16'h1234);
        check("rst_idle", {busy, if_done, d_done, mem_rd, mem_wr, mem_addr, mem_wdata}, 32'd0);
        check("rst_rdata", {if_rdata, d_rdata}, 32'd0);
        rst = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("rst_no_done", {if_done, d_done}, 32'd0);
        ref_mem[8'h05] = 16'h1234;
        m_d_rdata = 16'h0; m_if_rdata = 16'h0; m_last_data = 1'b0;

        // both requests held continuously
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        seq = ""; cyc = 0; n_done = 0;
        while (n_done < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (d_done || if_done) begin
                seq = {seq, d_done ? "d" : "f"};
                done_at[n_done] = cyc;
                n_done++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_seq = "dfdf";
        m_if_rdata = ref_mem[8'h10]; m_last_data = 1'b0;
`else
        exp_seq = "dddd";
        m_last_data = 1'b1;
`endif
        m_d_rdata = ref_mem[8'h20];
        n_checks++;
        if (seq != exp_seq) begin
            n_fail++;
            $display("FAIL cont_grant_order: got %s expected %s", seq, exp_seq);
        end
        if (n_done == 4) begin
            for (int k = 0; k < 4; k++) check("cont_done_cycle", done_at[k], 2 + 3 * k);
        end
        check("cont_rdata", {if_rdata, d_rdata}, {m_if_rdata, m_d_rdata});

        // randomized rounds against the model
        for (int r = 0; r < 40; r++) begin
            int          kind;
            bit          uf, ud, we;
            logic [7:0]  fa, da;
            logic [15:0] wd;
            kind = $urandom_range(0, 2);
            uf = (kind != 1);
            ud = (kind != 0);
            we = $urandom_range(0, 1);
            fa = 8'($urandom_range(0, 15));
            da = 8'($urandom_range(0, 15));
            wd = 16'($urandom);
            predict(uf, ud, we, fa, da, wd, dfx, eif, ed);
            run_pair(uf, ud, we, fa, da, wd, dfx, eif, ed);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
